// File: rtl/draw_compositor_if.sv
// Sprite-side bus of the pixel compositor: per-layer hits and colours in,
// composited pixel, hit information and blink status out.
interface draw_compositor_if #(
  parameter int NUM_LAYERS = 17,
  parameter int COLOR_W    = 3
);
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                          pix_tick;
  logic                          video_on;
  logic [9:0]                    hcount;
  logic [9:0]                    vcount;
  logic [NUM_LAYERS-1:0]         layer_on;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         blink_mask;
  logic                          hl_en;
  logic [IDX_W-1:0]              hl_idx;

  logic [COLOR_W-1:0]            rgb;
  logic [NUM_LAYERS-1:0]         sel;
  logic                          hit_valid;
  logic [IDX_W-1:0]              hit_idx;
  logic                          blink_phase;
  logic                          frame_start;

  // Sprite generators / sync side.
  modport master (
    output pix_tick, video_on, hcount, vcount, layer_on, layer_rgb,
           blink_mask, hl_en, hl_idx,
    input  rgb, sel, hit_valid, hit_idx, blink_phase, frame_start
  );

  // Compositor side.
  modport slave (
    input  pix_tick, video_on, hcount, vcount, layer_on, layer_rgb,
           blink_mask, hl_en, hl_idx,
    output rgb, sel, hit_valid, hit_idx, blink_phase, frame_start
  );
endinterface

// File: rtl/draw_compositor.sv
// Two-stage pixel compositor: blink/blank masking in stage 1, fixed-priority
// layer resolve with cursor highlight in stage 2, plus a per-frame blink engine.
module draw_compositor #(
  parameter int                NUM_LAYERS   = 17,
  parameter int                COLOR_W      = 3,
  parameter int                BLINK_FRAMES = 30,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 3'b000,
  parameter logic [COLOR_W-1:0] HL_XOR      = 3'b111
) (
  input  logic            clk,
  input  logic            reset,
  draw_compositor_if.slave bus
);
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 1 registers
  logic [NUM_LAYERS-1:0]         s1_on;
  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
  logic                          s1_video;
  logic                          s1_hl_en;
  logic [IDX_W-1:0]              s1_hl_idx;

  // Stage 2 (output) registers
  logic [COLOR_W-1:0]            rgb_q;
  logic [NUM_LAYERS-1:0]         sel_q;
  logic                          hit_valid_q;
  logic [IDX_W-1:0]              hit_idx_q;

  // Blink engine
  logic [CNT_W-1:0]              frame_cnt;
  logic                          blink_q;
  logic                          boundary;

  // Combinational intermediates
  logic [NUM_LAYERS-1:0]         eff_in;
  logic                          win_valid;
  logic [IDX_W-1:0]              win_idx;
  logic [COLOR_W-1:0]            win_rgb;
  logic                          hl_hit;
  logic [COLOR_W-1:0]            comp_rgb;

  assign boundary        = bus.pix_tick && (bus.hcount == '0) && (bus.vcount == '0);
  // Same-cycle pulse, gated so it reads 0 while reset is held.
  assign bus.frame_start = boundary && !reset;
  assign bus.blink_phase = blink_q;
  assign bus.rgb         = rgb_q;
  assign bus.sel         = sel_q;
  assign bus.hit_valid   = hit_valid_q;
  assign bus.hit_idx     = hit_idx_q;

  // Hide blinking layers during the off phase and everything outside the visible area.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_in = '0;
    if (bus.video_on)
      eff_in = bus.layer_on & ~(bus.blink_mask & {NUM_LAYERS{blink_q}});
  end

  // Stage 1: capture masked hits and the attributes that travel with them.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_on     <= '0;
      s1_rgb    <= '0;
      s1_video  <= 1'b0;
      s1_hl_en  <= 1'b0;
      s1_hl_idx <= '0;
    end else if (bus.pix_tick) begin
      s1_on     <= eff_in;
      s1_rgb    <= bus.layer_rgb;
      s1_video  <= bus.video_on;
      s1_hl_en  <= bus.hl_en;
      s1_hl_idx <= bus.hl_idx;
    end
  end

  // Blink engine: count frames, flip the phase every BLINK_FRAMES boundaries.
  // The new phase is seen by stage 1 from the tick after the boundary onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_q   <= !blink_q;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // Priority resolve: ascending scan, so the highest set index is the last to win.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_rgb   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_on[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_rgb   = s1_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Highlight and background selection. win_idx is always < NUM_LAYERS,
  // so an out-of-range hl_idx can never match.
  always_comb begin
    hl_hit   = s1_hl_en && win_valid && (s1_hl_idx == win_idx);
    comp_rgb = s1_video ? BG_COLOR : '0;
    if (win_valid)
      comp_rgb = hl_hit ? (win_rgb ^ HL_XOR) : win_rgb;
  end

  // Stage 2: register the composited pixel and hit information.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q       <= '0;
      sel_q       <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
    end else if (bus.pix_tick) begin
      rgb_q       <= comp_rgb;
      sel_q       <= s1_on;
      hit_valid_q <= win_valid;
      hit_idx_q   <= win_idx;
    end
  end
endmodule

// File: tb/tb_draw_compositor.sv
// Directed bench for draw_compositor with a cycle-by-cycle reference model.
module tb_draw_compositor;
  localparam int NL    = 17;
  localparam int CW    = 3;
  localparam int BLINK = 2;

  typedef struct packed {
    logic [CW-1:0] rgb;
    logic [NL-1:0] sel;
    logic          hit_valid;
    logic [4:0]    hit_idx;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   mdl_on = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  draw_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  draw_compositor #(
    .NUM_LAYERS  (NL),
    .COLOR_W     (CW),
    .BLINK_FRAMES(BLINK),
    .BG_COLOR    (3'b000),
    .HL_XOR      (3'b111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the pixel must look like, straight from the layer rules.
  function automatic exp_t compose(input logic [NL-1:0] on, input logic [NL-1:0] mask,
                                   input logic phase, input logic vid,
                                   input logic [NL*CW-1:0] cols, input logic hen,
                                   input logic [4:0] hidx);
    exp_t r;
    logic [NL-1:0] vis;
    bit found;
    vis = vid ? (on & ~(phase ? mask : '0)) : '0;
    r.sel       = vis;
    r.hit_valid = |vis;
    r.hit_idx   = '0;
    r.rgb       = vid ? 3'b000 : 3'b000;
    found = 0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (!found && vis[i]) begin
        found     = 1;
        r.hit_idx = 5'(i);
        r.rgb     = cols[i*CW +: CW];
        if (hen && (int'(hidx) == i)) r.rgb = r.rgb ^ 3'b111;
      end
    end
    return r;
  endfunction

  // Model state: blink phase derived from the number of frames seen so far.
  exp_t m_p1, m_out;
  int   m_frames;
  logic m_phase;
  assign m_phase = ((m_frames / BLINK) % 2) == 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p1     <= '0;
      m_out    <= '0;
      m_frames <= 0;
    end else if (bus.pix_tick) begin
      m_p1  <= compose(bus.layer_on, bus.blink_mask, m_phase, bus.video_on,
                       bus.layer_rgb, bus.hl_en, bus.hl_idx);
      m_out <= m_p1;
      if (bus.hcount == 10'd0 && bus.vcount == 10'd0) m_frames <= m_frames + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mdl_on) begin
      check("mdl_rgb",       64'(bus.rgb),         64'(m_out.rgb));
      check("mdl_sel",       64'(bus.sel),         64'(m_out.sel));
      check("mdl_hit_valid", 64'(bus.hit_valid),   64'(m_out.hit_valid));
      check("mdl_hit_idx",   64'(bus.hit_idx),     64'(m_out.hit_idx));
      check("mdl_blink",     64'(bus.blink_phase), 64'(m_phase));
      check("mdl_frame_start", 64'(bus.frame_start),
            64'(!reset && bus.pix_tick && bus.hcount == 10'd0 && bus.vcount == 10'd0));
    end
  end

  task automatic step(input logic t);
    bus.pix_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic set_color(input int idx, input logic [CW-1:0] c);
    bus.layer_rgb[idx*CW +: CW] = c;
  endtask

  logic       phase_at_boundary [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] rgb_after_boundary [4] = '{3'b100, 3'b011, 3'b011, 3'b100};

  initial begin
    bus.pix_tick   = 1'b0;
    bus.video_on   = 1'b1;
    bus.hcount     = 10'd5;
    bus.vcount     = 10'd5;
    bus.layer_on   = '0;
    bus.layer_rgb  = '0;
    bus.blink_mask = '0;
    bus.hl_en      = 1'b0;
    bus.hl_idx     = '0;

    #1 reset = 1'b1;
    #1 mdl_on = 1'b1;
    check("rst_rgb", 64'(bus.rgb), 64'd0);
    check("rst_sel", 64'(bus.sel), 64'd0);
    check("rst_hit_valid", 64'(bus.hit_valid), 64'd0);
    check("rst_blink", 64'(bus.blink_phase), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Background with no layers on.
    step(1); step(1);
    check("bg_rgb", 64'(bus.rgb), 64'd0);
    check("bg_hit_valid", 64'(bus.hit_valid), 64'd0);
    step(1);
    check("bg_rgb_t3", 64'(bus.rgb), 64'd0);

    // Reset in the middle of a run clears outputs at once.
    bus.layer_on = 17'h10000;
    set_color(16, 3'b101);
    step(1); step(1);
    check("pre_rst_hit_valid", 64'(bus.hit_valid), 64'd1);
    check("pre_rst_rgb", 64'(bus.rgb), 64'b101);
    reset = 1'b1;
    #1;
    check("mid_rst_rgb", 64'(bus.rgb), 64'd0);
    check("mid_rst_hit_valid", 64'(bus.hit_valid), 64'd0);
    check("mid_rst_sel", 64'(bus.sel), 64'd0);
    check("mid_rst_hit_idx", 64'(bus.hit_idx), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Overlap: layer 16 over layer 3, then layer 3 alone.
    bus.layer_on = 17'h10008;
    set_color(3, 3'b010);
    set_color(16, 3'b101);
    step(1); step(1);
    check("ovl_rgb", 64'(bus.rgb), 64'b101);
    check("ovl_hit_idx", 64'(bus.hit_idx), 64'd16);
    check("ovl_sel", 64'(bus.sel), 64'h10008);
    bus.layer_on = 17'h00008;
    step(1);
    check("ovl_latency_hold", 64'(bus.rgb), 64'b101);
    step(1);
    check("low_rgb", 64'(bus.rgb), 64'b010);
    check("low_hit_idx", 64'(bus.hit_idx), 64'd3);

    // Blanking outside the visible area.
    bus.layer_on = 17'h00020;
    bus.video_on = 1'b0;
    step(1); step(1);
    check("blank_rgb", 64'(bus.rgb), 64'd0);
    check("blank_sel", 64'(bus.sel), 64'd0);
    check("blank_hit_valid", 64'(bus.hit_valid), 64'd0);

    // Highlight in range and out of range.
    bus.video_on = 1'b1;
    bus.layer_on = 17'h00080;
    set_color(7, 3'b001);
    bus.hl_en    = 1'b1;
    bus.hl_idx   = 5'd7;
    step(1); step(1);
    check("hl_rgb", 64'(bus.rgb), 64'b110);
    bus.hl_idx = 5'd20;
    step(1); step(1);
    check("hl_oob_rgb", 64'(bus.rgb), 64'b001);

    // Blink over four frames: blinking upper layer 1 over steady layer 0.
    bus.hl_en      = 1'b0;
    bus.layer_on   = 17'h00003;
    bus.blink_mask = 17'h00002;
    set_color(0, 3'b011);
    set_color(1, 3'b100);
    for (int k = 0; k < 4; k++) begin
      bus.hcount   = 10'd0;
      bus.vcount   = 10'd0;
      bus.pix_tick = 1'b1;
      #1;
      check("blink_phase_at_boundary", 64'(bus.blink_phase), 64'(phase_at_boundary[k]));
      check("frame_start_pulse", 64'(bus.frame_start), 64'd1);
      @(posedge clk);
      #1;
      bus.hcount = 10'd5;
      bus.vcount = 10'd5;
      step(1); step(1); step(1);
      check("blink_rgb", 64'(bus.rgb), 64'(rgb_after_boundary[k]));
    end

    // pix_tick gated: nothing moves, no frame pulse even on a boundary position.
    for (int i = 0; i < 10; i++) begin
      bus.layer_on = 17'h10000 ^ 17'(i);
      bus.video_on = i[0];
      bus.hcount   = 10'd0;
      bus.vcount   = 10'd0;
      step(0);
    end
    check("gate_frame_start", 64'(bus.frame_start), 64'd0);
    check("gate_rgb", 64'(bus.rgb), 64'b100);
    check("gate_hit_idx", 64'(bus.hit_idx), 64'd1);
    check("gate_sel", 64'(bus.sel), 64'h00003);
    check("gate_blink", 64'(bus.blink_phase), 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
